// File: rtl/register_dump_reader.sv
// Streams registers 0..NUM_REGS-1 out over a valid/ready port, one word per two cycles.
// Optional: define CHECKSUM_EN to append an XOR checksum word after the last register.
module register_dump_reader #(
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [SEL_W-1:0] reg_sel,
    input  logic [15:0]      reg_data,
    output logic [15:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
`ifdef CHECKSUM_EN
        CSUM,
`endif
        DONE
    } state_t;

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REGS - 1);

    state_t           state;
    logic [SEL_W-1:0] idx;
`ifdef CHECKSUM_EN
    logic [15:0]      csum;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            reg_sel   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx     <= '0;
                        reg_sel <= '0;
                        busy    <= 1'b1;
`ifdef CHECKSUM_EN
                        csum    <= '0;
`endif
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    out_data  <= reg_data;
                    out_valid <= 1'b1;
`ifdef CHECKSUM_EN
                    out_last  <= 1'b0;
`else
                    out_last  <= (idx == LAST_IDX);
`endif
                    state     <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
`ifdef CHECKSUM_EN
                        csum      <= csum ^ out_data;
`endif
                        if (idx != LAST_IDX) begin
                            // reg_sel moves only here so it is stable for the following LOAD
                            idx     <= idx + 1'b1;
                            reg_sel <= idx + 1'b1;
                            state   <= LOAD;
                        end else begin
`ifdef CHECKSUM_EN
                            // accumulator does not yet include the word just accepted
                            out_data  <= csum ^ out_data;
                            out_valid <= 1'b1;
                            out_last  <= 1'b1;
                            state     <= CSUM;
`else
                            done      <= 1'b1;
                            state     <= DONE;
`endif
                        end
                    end
                end
`ifdef CHECKSUM_EN
                CSUM: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
`endif
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
